// File: rtl/sobel_edge_pipeline.sv
// Pipelined 3x3 Sobel edge-magnitude stage with per-frame edge counting.
// Optional build macro SOBEL_BINARIZE_EN: edgePixel becomes 4'hF/4'h0 from the threshold test.
module sobel_edge_pipeline #(
    parameter logic [6:0] THRESH_RESET = 7'd40
) (
    input  logic        mainClk,
    input  logic        nreset,
    input  logic [3:0]  pixelData [3][3],
    input  logic        pixelDataValid,
    input  logic [9:0]  spiXVal,
    input  logic [8:0]  spiYVal,
    input  logic [6:0]  threshold,
    output logic        edgeValid,
    output logic [3:0]  edgePixel,
    output logic [9:0]  edgeXVal,
    output logic [8:0]  edgeYVal,
    output logic [18:0] frameEdgeCount,
    output logic        frameDone
);

    localparam logic [18:0] COUNT_MAX = '1;

    // Index 0 covers the left column / top row, index 1 the right column / bottom row.
    logic [5:0] col_sum [2];
    logic [5:0] row_sum [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sums
            localparam int E = 2 * gi;
            assign col_sum[gi] = {2'b00, pixelData[0][E]} + {1'b0, pixelData[1][E], 1'b0}
                               + {2'b00, pixelData[2][E]};
            assign row_sum[gi] = {2'b00, pixelData[E][0]} + {1'b0, pixelData[E][1], 1'b0}
                               + {2'b00, pixelData[E][2]};
        end
    endgenerate

    logic [2:0] valid_pipe;

    logic [5:0] s1_l, s1_r, s1_t, s1_b;
    logic [9:0] s1_x;
    logic [8:0] s1_y;
    logic       s1_border;

    logic [5:0] s2_ax, s2_ay;
    logic [9:0] s2_x;
    logic [8:0] s2_y;
    logic       s2_border;

    logic [6:0] s3_mag;
    logic [9:0] s3_x;
    logic [8:0] s3_y;
    logic       s3_border;

    logic [6:0]  thresh_reg;
    logic [18:0] edge_count;

    logic signed [6:0] gx, gy;
    logic [6:0] gx_abs, gy_abs;
    logic [6:0] mag_next;
    logic       is_edge;
    logic       is_boundary;
    logic [3:0] pixel_next;

    always_comb begin
        gx       = signed'({1'b0, s1_r}) - signed'({1'b0, s1_l});
        gy       = signed'({1'b0, s1_b}) - signed'({1'b0, s1_t});
        gx_abs   = gx[6] ? 7'(-gx) : 7'(gx);
        gy_abs   = gy[6] ? 7'(-gy) : 7'(gy);
        mag_next = {1'b0, s2_ax} + {1'b0, s2_ay};
    end

    // Boundary detection uses the raw x, before the border clamp.
    always_comb begin
        is_edge     = (s3_mag >= thresh_reg) && !s3_border;
        is_boundary = (s3_x == 10'd0) && (s3_y == 9'd0);
`ifdef SOBEL_BINARIZE_EN
        pixel_next  = is_edge ? 4'hF : 4'h0;
`else
        pixel_next  = s3_border ? 4'h0 : s3_mag[6:3];
`endif
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            valid_pipe <= '0;
            thresh_reg <= THRESH_RESET;
        end else begin
            valid_pipe <= {valid_pipe[1:0], pixelDataValid};
            thresh_reg <= threshold;
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s1_l      <= '0;
            s1_r      <= '0;
            s1_t      <= '0;
            s1_b      <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_border <= 1'b0;
        end else if (pixelDataValid) begin
            s1_l      <= col_sum[0];
            s1_r      <= col_sum[1];
            s1_t      <= row_sum[0];
            s1_b      <= row_sum[1];
            s1_x      <= spiXVal;
            s1_y      <= spiYVal;
            s1_border <= (spiXVal < 10'd2);
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s2_ax     <= '0;
            s2_ay     <= '0;
            s2_x      <= '0;
            s2_y      <= '0;
            s2_border <= 1'b0;
        end else if (valid_pipe[0]) begin
            s2_ax     <= gx_abs[5:0];
            s2_ay     <= gy_abs[5:0];
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_border <= s1_border;
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s3_mag    <= '0;
            s3_x      <= '0;
            s3_y      <= '0;
            s3_border <= 1'b0;
        end else if (valid_pipe[1]) begin
            s3_mag    <= mag_next;
            s3_x      <= s2_x;
            s3_y      <= s2_y;
            s3_border <= s2_border;
        end
    end

    // Output register: edge decision, coordinates and frame accounting.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            edgeValid      <= 1'b0;
            edgePixel      <= '0;
            edgeXVal       <= '0;
            edgeYVal       <= '0;
            frameEdgeCount <= '0;
            frameDone      <= 1'b0;
            edge_count     <= '0;
        end else begin
            edgeValid <= valid_pipe[2];
            frameDone <= 1'b0;
            if (valid_pipe[2]) begin
                edgePixel <= pixel_next;
                edgeXVal  <= s3_border ? 10'd0 : s3_x - 10'd1;
                edgeYVal  <= s3_y;
                if (is_boundary) begin
                    frameEdgeCount <= edge_count;
                    frameDone      <= 1'b1;
                    edge_count     <= {18'd0, is_edge};
                end else if (is_edge && edge_count != COUNT_MAX) begin
                    edge_count <= edge_count + 19'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_pipeline.sv
// Directed bench for sobel_edge_pipeline: hand-computed window magnitudes,
// a four-deep expected-beat delay line, and explicit frame-count checks.
module tb_sobel_edge_pipeline;

    logic        mainClk = 1'b0;
    logic        nreset;
    logic [3:0]  pix [3][3];
    logic        pixelDataValid;
    logic [9:0]  spiXVal;
    logic [8:0]  spiYVal;
    logic [6:0]  threshold;
    logic        edgeValid;
    logic [3:0]  edgePixel;
    logic [9:0]  edgeXVal;
    logic [8:0]  edgeYVal;
    logic [18:0] frameEdgeCount;
    logic        frameDone;

    int checks = 0;
    int errors = 0;

    // Expected-beat delay line: slot 3 is the beat driven four falling edges ago.
    bit       sv   [4];
    int       sx   [4];
    int       sy   [4];
    int       smag [4];
    bit       sedge[4];
    bit       m_ev, m_fd;
    int       m_pix, m_x, m_y, m_fcount, m_cnt;

    sobel_edge_pipeline #(.THRESH_RESET(7'd40)) dut (
        .mainClk        (mainClk),
        .nreset         (nreset),
        .pixelData      (pix),
        .pixelDataValid (pixelDataValid),
        .spiXVal        (spiXVal),
        .spiYVal        (spiYVal),
        .threshold      (threshold),
        .edgeValid      (edgeValid),
        .edgePixel      (edgePixel),
        .edgeXVal       (edgeXVal),
        .edgeYVal       (edgeYVal),
        .frameEdgeCount (frameEdgeCount),
        .frameDone      (frameDone)
    );

    always #5 mainClk = ~mainClk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hand-computed |Gx|+|Gy| for each window kind.
    function automatic int mag_of(input int kind);
        case (kind)
            1, 2, 5: return 60;  // vertical step, inverted vertical step, horizontal step
            3:       return 20;  // gentle ramp 3/5/8 across columns
            4:       return 30;  // single bright pixel at bottom-right
            default: return 0;   // flat grey
        endcase
    endfunction

    task automatic set_window(input int kind);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                case (kind)
                    1:       pix[r][c] = (c == 0) ? 4'd0 : 4'd15;
                    2:       pix[r][c] = (c == 0) ? 4'd15 : 4'd0;
                    3:       pix[r][c] = (c == 0) ? 4'd3 : ((c == 1) ? 4'd5 : 4'd8);
                    4:       pix[r][c] = (r == 2 && c == 2) ? 4'd15 : 4'd0;
                    5:       pix[r][c] = (r == 0) ? 4'd0 : 4'd15;
                    default: pix[r][c] = 4'd7;
                endcase
            end
        end
    endtask

    function automatic int exp_pixel(input int mag, input bit edge_hit, input int x);
`ifdef SOBEL_BINARIZE_EN
        return edge_hit ? 15 : 0;
`else
        return (x < 2) ? 0 : (mag >> 3);
`endif
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0; sx[i] = 0; sy[i] = 0; smag[i] = 0; sedge[i] = 1'b0;
        end
        m_ev = 1'b0; m_fd = 1'b0; m_pix = 0; m_x = 0; m_y = 0; m_fcount = 0; m_cnt = 0;
    endtask

    task automatic cycle(input bit v, input int kind, input int x, input int y);
        @(negedge mainClk);
        m_ev = sv[3];
        m_fd = 1'b0;
        if (sv[3]) begin
            m_pix = exp_pixel(smag[3], sedge[3], sx[3]);
            m_x   = (sx[3] < 2) ? 0 : sx[3] - 1;
            m_y   = sy[3];
            if (sx[3] == 0 && sy[3] == 0) begin
                m_fcount = m_cnt;
                m_fd     = 1'b1;
                m_cnt    = sedge[3] ? 1 : 0;
            end else if (sedge[3] && m_cnt < 524287) begin
                m_cnt = m_cnt + 1;
            end
        end
        check("edgeValid", edgeValid, m_ev);
        check("edgePixel", edgePixel, m_pix);
        check("edgeXVal", edgeXVal, m_x);
        check("edgeYVal", edgeYVal, m_y);
        check("frameDone", frameDone, m_fd);
        check("frameEdgeCount", frameEdgeCount, m_fcount);
        for (int i = 3; i > 0; i--) begin
            sv[i] = sv[i-1]; sx[i] = sx[i-1]; sy[i] = sy[i-1];
            smag[i] = smag[i-1]; sedge[i] = sedge[i-1];
        end
        sv[0]    = v;
        sx[0]    = x;
        sy[0]    = y;
        smag[0]  = mag_of(kind);
        sedge[0] = v && (mag_of(kind) >= int'(threshold)) && (x >= 2);
        set_window(kind);
        pixelDataValid = v;
        spiXVal        = 10'(x);
        spiYVal        = 9'(y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_edgeValid"}, edgeValid, 0);
        check({phase, "_edgePixel"}, edgePixel, 0);
        check({phase, "_edgeXVal"}, edgeXVal, 0);
        check({phase, "_edgeYVal"}, edgeYVal, 0);
        check({phase, "_frameEdgeCount"}, frameEdgeCount, 0);
        check({phase, "_frameDone"}, frameDone, 0);
    endtask

    initial begin
        nreset         = 1'b0;
        pixelDataValid = 1'b0;
        spiXVal        = '0;
        spiYVal        = '0;
        threshold      = 7'd40;
        set_window(0);
        clear_model();
        repeat (2) @(negedge mainClk);
        check_all_zero("reset");
        nreset = 1'b1;

        // Flat window, then single edges of each shape and both border columns.
        cycle(1'b1, 0, 5, 3);
        idle(5);
        cycle(1'b1, 1, 10, 3);
        idle(5);
        cycle(1'b1, 3, 20, 4);
        cycle(1'b1, 4, 30, 4);
        cycle(1'b1, 2, 40, 4);
        cycle(1'b1, 5, 50, 4);
        cycle(1'b1, 1, 1, 4);
        cycle(1'b1, 1, 2, 4);
        idle(5);
        cycle(1'b1, 0, 0, 0);
        idle(5);
        check("frame1_count", frameEdgeCount, 4);

        // Eight back-to-back beats alternating flat and step.
        for (int i = 0; i < 8; i++) cycle(1'b1, (i % 2 == 1) ? 1 : 0, 100 + i, 7);
        idle(5);

        // Threshold boundary: mag 30 counts at threshold 30, not at 31.
        threshold = 7'd30;
        cycle(1'b1, 4, 60, 8);
        idle(5);
        threshold = 7'd31;
        cycle(1'b1, 4, 61, 8);
        idle(5);
        threshold = 7'd40;
        cycle(1'b1, 0, 0, 0);
        idle(5);
        check("frame2_count", frameEdgeCount, 5);

        cycle(1'b1, 1, 10, 1);
        cycle(1'b1, 2, 11, 1);
        idle(5);
        cycle(1'b1, 0, 0, 0);
        idle(5);
        check("frame3_count", frameEdgeCount, 2);

        // Mid-stream reset with two beats in flight and a non-zero counter.
        cycle(1'b1, 1, 12, 2);
        idle(5);
        cycle(1'b1, 1, 10, 2);
        cycle(1'b1, 1, 11, 2);
        cycle(1'b0, 0, 0, 0);
        #2 nreset = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge mainClk);
        nreset = 1'b1;
        clear_model();
        idle(6);
        cycle(1'b1, 0, 0, 0);
        idle(3);
        cycle(1'b0, 0, 0, 0);
        check("post_reset_frameDone", frameDone, 1);
        check("post_reset_count", frameEdgeCount, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_edge_pipeline.md
# sobel_edge_pipeline

Pipelined Sobel edge-magnitude stage directly downstream of the SPI pixel-window controller. Accepts one 3×3 window of 4-bit grey pixels per valid beat, with that window's coordinates. Produces a 4-bit edge value per beat, plus a per-frame edge count for the host/display side. Fixed 3-cycle latency, no backpressure, one window accepted every `mainClk` cycle.

## Interface

Parameters:
- `THRESH_RESET` (default 7'd40): reset value of the edge threshold used for edge counting and binarisation.

Ports:
- `mainClk`  input  1  sole clock; everything is on its rising edge.
- `nreset`  input  1  reset, asynchronous, active-low.
- `pixelData[3][3]`  input  4 each  window, `[row][col]`; row 0 = top, col 0 = oldest/left, col 2 = newest/right.
- `pixelDataValid`  input  1  window and coordinates valid this cycle.
- `spiXVal`  input  10  x coordinate of newest column.
- `spiYVal`  input  9  y coordinate of window.
- `threshold`  input  7  edge threshold; sampled in stage 3 each cycle.
- `edgeValid`  output  1  `edgePixel` and coordinates valid.
- `edgePixel`  output  4  edge result.
- `edgeXVal`  output  10  input x minus 1 (window centre), 0 for border beats.
- `edgeYVal`  output  9  input y, delayed.
- `frameEdgeCount`  output  19  edge count of the last completed frame.
- `frameDone`  output  1  one-cycle pulse when `frameEdgeCount` updates.

## Operation

- Stage 1 (on valid): left column sum `L = p00 + 2·p10 + p20`, right `R = p02 + 2·p12 + p22`, top row `T = p00 + 2·p01 + p02`, bottom `B = p20 + 2·p21 + p22`. Each is 6-bit unsigned (max 60). Register them with x, y and a border flag. Border flag = `spiXVal < 2`.
- Stage 2: `Gx = R − L`, `Gy = B − T`, 7-bit signed. Register `|Gx|` and `|Gy|` as 6-bit values.
- Stage 3: `mag = |Gx| + |Gy|`, 7-bit (max 120). `isEdge = (mag >= threshold) && !border`.
  - `edgePixel = border ? 0 : mag[6:3]`. Never saturates, since 120>>3 = 15.
  - `edgeXVal = border ? 0 : x − 1`.
- Valid propagates through a 3-bit shift pipeline. Data registers load only when their stage input is valid and otherwise hold their value.
- Edge counter (19-bit, saturates at 2^19−1):
  - Increments on each stage-3 valid beat with `isEdge`.
  - Frame boundary = stage-3 valid beat with pre-border x (input `spiXVal`) == 0 and y == 0.
  - On that beat, `frameEdgeCount` ← current counter and `frameDone` = 1 (one cycle). The counter reloads to `isEdge` of that beat, so the boundary beat counts toward the new frame.
  - The first boundary after reset still pulses, reporting 0.

## Timing

- Latency: a beat sampled with `pixelDataValid` at edge N appears with `edgeValid` = 1 after edge N+3.
- Throughput: one beat per cycle. Gaps propagate unchanged; outputs hold their last value while `edgeValid` = 0.
- `frameDone` asserts in the same cycle as the boundary `edgeValid` beat.
- Reset (asynchronous, any time including mid-stream):
  - all valid bits, `edgeValid`, `frameDone` = 0
  - `edgePixel` = 0, `edgeXVal` = 0, `edgeYVal` = 0
  - `frameEdgeCount` = 0, counter = 0
  - in-flight beats are discarded
  - stored threshold = `THRESH_RESET`
- `threshold` port change takes effect on the next stage-3 evaluation. There is no synchronisation requirement; it is `mainClk`-domain.

## Configuration

- `SOBEL_BINARIZE_EN`:
  - Defined: `edgePixel = isEdge ? 4'hF : 4'h0`.
  - Undefined: `edgePixel = mag[6:3]`, with border forcing 0.
  - Counting, `frameDone` and latency are identical in both builds.

## Test plan

- Flat window, all pixels 4'h7, x = 5, y = 3, valid for 1 cycle -> 3 cycles later `edgeValid` = 1, `edgePixel` = 0, `edgeXVal` = 4, `edgeYVal` = 3; count unchanged.
- Vertical step, col 0 = 0, cols 1–2 = 15, x = 10 -> `Gx` = 60, `Gy` = 0, mag = 60, `edgePixel` = 7 (or 4'hF with `SOBEL_BINARIZE_EN`, threshold 40), counter +1.
- Same step window at x = 1 -> `edgePixel` = 0, `edgeXVal` = 0, no count.
- Back-to-back valid for 8 cycles with alternating flat/step windows, threshold = 40 -> 8 consecutive output beats in order; counter +4.
- 5 edge beats, then a beat with x = 0, y = 0 -> `frameDone` pulses once, `frameEdgeCount` = 5; the next frame's counter starts at 0.
- Assert `nreset` low with 2 beats in flight -> no `edgeValid` after release; all outputs 0; first post-reset boundary reports `frameEdgeCount` = 0.
